// File: rtl/bnn_pkg.sv
// Shared BNN pipeline definitions: pool FSM states and the default image sizes
// so the conv and pool stages agree on one source of truth.
package bnn_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POOL = 2'd1,
        DONE = 2'd2
    } pool_state_t;

    localparam int unsigned CONV_IN_SIZE  = 30;
    localparam int unsigned CONV_OUT_SIZE = CONV_IN_SIZE - 2;
    localparam int unsigned POOL_IN_SIZE  = CONV_OUT_SIZE;
    localparam int unsigned POOL_OUT_SIZE = POOL_IN_SIZE / 2;

    // Counter/index width that never collapses to zero bits.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bin_maxpool_core_if.sv
// Map-level handshake between the conv stage, the pool core and the next layer.
interface bin_maxpool_core_if #(
    parameter int unsigned IMG_IN_SIZE  = 28,
    parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE / 2
);
    logic                                 in_valid;
    logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0]   img_in;
    logic [IMG_OUT_SIZE*IMG_OUT_SIZE-1:0] img_out;
    logic                                 out_valid;
    logic                                 busy;
    logic                                 overrun;

    modport master (
        output in_valid, img_in,
        input  img_out, out_valid, busy, overrun
    );

    modport slave (
        input  in_valid, img_in,
        output img_out, out_valid, busy, overrun
    );
endinterface

// File: rtl/bin_maxpool_core_pool_window.sv
// Combinational 2x2 window OR (binary max) for output pixel (orow, ocol).
module pool_window
    import bnn_pkg::*;
#(
    parameter  int unsigned IMG_IN_SIZE  = POOL_IN_SIZE,
    parameter  int unsigned IMG_OUT_SIZE = IMG_IN_SIZE / 2,
    localparam int unsigned CW           = cnt_width(IMG_OUT_SIZE)
) (
    input  logic [IMG_IN_SIZE*IMG_IN_SIZE-1:0] img_i,
    input  logic [CW-1:0]                      orow_i,
    input  logic [CW-1:0]                      ocol_i,
    output logic                               win_c
);
    localparam int unsigned AW = cnt_width(IMG_IN_SIZE * IMG_IN_SIZE);

    logic [AW-1:0] base;

    // Top-left input pixel of the window: (2*orow, 2*ocol).
    assign base  = AW'(32'(orow_i) * 2 * IMG_IN_SIZE + 32'(ocol_i) * 2);

    assign win_c = img_i[base]
                 | img_i[base + AW'(1)]
                 | img_i[base + AW'(IMG_IN_SIZE)]
                 | img_i[base + AW'(IMG_IN_SIZE + 1)];
endmodule

// File: rtl/bin_maxpool_core.sv
// Binary 2x2/stride-2 max-pool: captures a map on in_valid, pools one pixel per
// cycle, then publishes the pooled map with a one-cycle out_valid.
module bin_maxpool_core
    import bnn_pkg::*;
#(
    parameter int unsigned IMG_IN_SIZE  = POOL_IN_SIZE,
    parameter int unsigned IMG_OUT_SIZE = IMG_IN_SIZE / 2
) (
    input logic               clk,
    input logic               rst_n,
    bin_maxpool_core_if.slave bus
);
    localparam int unsigned IW = IMG_IN_SIZE * IMG_IN_SIZE;
    localparam int unsigned OW = IMG_OUT_SIZE * IMG_OUT_SIZE;
    localparam int unsigned CW = cnt_width(IMG_OUT_SIZE);
    localparam int unsigned PW = cnt_width(OW);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_POOL = 2'(POOL);
    localparam logic [1:0] ST_DONE = 2'(DONE);

    localparam logic [CW-1:0] LAST = CW'(IMG_OUT_SIZE - 1);

    if (IMG_IN_SIZE < 2) begin : g_size_chk
        $error("bin_maxpool_core: IMG_IN_SIZE must be >= 2");
    end

    logic [1:0]    state_q,     state_d;
    logic [CW-1:0] orow_q,      orow_d;
    logic [CW-1:0] ocol_q,      ocol_d;
    logic [IW-1:0] cap_q,       cap_d;
    logic [OW-1:0] work_q,      work_d;
    logic [OW-1:0] img_out_q,   img_out_d;
    logic          out_valid_q, out_valid_d;
    logic          busy_q,      busy_d;
    logic          overrun_q,   overrun_d;

    logic          win_c;
    logic [PW-1:0] pix_idx;

    pool_window #(
        .IMG_IN_SIZE  (IMG_IN_SIZE),
        .IMG_OUT_SIZE (IMG_OUT_SIZE)
    ) u_pool_window (
        .img_i  (cap_q),
        .orow_i (orow_q),
        .ocol_i (ocol_q),
        .win_c  (win_c)
    );

    assign pix_idx = PW'(32'(orow_q) * IMG_OUT_SIZE + 32'(ocol_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            orow_q      <= '0;
            ocol_q      <= '0;
            cap_q       <= '0;
            work_q      <= '0;
            img_out_q   <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            orow_q      <= orow_d;
            ocol_q      <= ocol_d;
            cap_q       <= cap_d;
            work_q      <= work_d;
            img_out_q   <= img_out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        orow_d      = orow_q;
        ocol_d      = ocol_q;
        cap_d       = cap_q;
        work_d      = work_q;
        img_out_d   = img_out_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    cap_d   = bus.img_in;
                    orow_d  = '0;
                    ocol_d  = '0;
                    state_d = ST_POOL;
                end
            end
            ST_POOL: begin
                work_d[pix_idx] = win_c;
                // A new map cannot be accepted mid-job; flag it and keep going.
                if (bus.in_valid) overrun_d = 1'b1;
                if (ocol_q == LAST) begin
                    ocol_d = '0;
                    if (orow_q == LAST) state_d = ST_DONE;
                    else                orow_d  = orow_q + CW'(1);
                end else begin
                    ocol_d = ocol_q + CW'(1);
                end
            end
            ST_DONE: begin
                img_out_d   = work_q;
                out_valid_d = 1'b1;
                if (bus.in_valid) begin
                    cap_d   = bus.img_in;
                    orow_d  = '0;
                    ocol_d  = '0;
                    state_d = ST_POOL;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign bus.img_out   = img_out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;
endmodule
